fsm_sched: RTL and testbench

FSM_SCHED -- requirements
Module: fsm_sched

---
 rtl/fsm_sched.sv | 207 ++++++++++++++++++++
 tb/tb_fsm_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fsm_sched.sv
// fsm_sched: round-robin run scheduler for two requesters.
// A granted requester's bit pattern drives an embedded five-state sequence
// machine for up to PW steps. Each step's state encoding is presented on
// out_val. The run finishes with a one-cycle done pulse tagged with the owner.
// Every output is a flop loaded from the next-state view of the controller.
module fsm_sched #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [PW-1:0] pat0,
    input  logic [PW-1:0] pat1,
    input  logic [3:0]    len0,
    input  logic [3:0]    len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          out_valid,
    output logic [2:0]    out_val,
    output logic          done,
    output logic          done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctl_e;

    // State values double as the out_val encoding, so no decode is needed.
    typedef enum logic [2:0] {
        ZERO   = 3'd2,
        TRES   = 3'd6,
        DOIS   = 3'd5,
        QUATRO = 3'd4,
        CINCO  = 3'd3
    } seq_e;

    // The length inputs are 4 bits wide, so any PW above 15 never clips them.
    localparam int         PW_CAP = (PW > 15) ? 15 : PW;
    localparam logic [3:0] PW_L   = PW_CAP[3:0];

    // Sequence machine transition for one step, driven by pattern bit a.
    function automatic seq_e seq_next(input seq_e s, input logic a);
        case (s)
            ZERO:    seq_next = TRES;
            TRES:    seq_next = a ? CINCO : DOIS;
            DOIS:    seq_next = QUATRO;
            QUATRO:  seq_next = a ? TRES : ZERO;
            CINCO:   seq_next = DOIS;
            default: seq_next = ZERO;
        endcase
    endfunction

    // Clip a requested length to the pattern width.
    function automatic logic [3:0] eff_len(input logic [3:0] len);
        if (len > PW_L) begin
            eff_len = PW_L;
        end else begin
            eff_len = len;
        end
    endfunction

    ctl_e          state_q,     state_d;
    seq_e          seq_q,       seq_d;
    logic [3:0]    step_q,      step_d;
    logic [3:0]    len_q,       len_d;
    logic [PW-1:0] pat_q,       pat_d;
    logic          prio1_q,     prio1_d;
    logic          owner_q,     owner_d;
    logic          gnt0_q,      gnt0_d;
    logic          gnt1_q,      gnt1_d;
    logic          busy_q,      busy_d;
    logic          out_valid_q, out_valid_d;
    logic [2:0]    out_val_q,   out_val_d;
    logic          done_q,      done_d;
    logic          done_id_q,   done_id_d;

    logic          win1_s;
    logic [PW-1:0] pat_shift_s;
    logic          step_bit_s;

    // Arbitration: a lone request wins outright; a tie goes to the prioritised requester.
    always_comb begin
        win1_s = 1'b0;
        if (req0 && req1) begin
            win1_s = prio1_q;
        end else begin
            win1_s = req1;
        end
    end

    // Select the latched pattern bit that belongs to the current step.
    always_comb begin
        pat_shift_s = pat_q >> step_q;
        step_bit_s  = pat_shift_s[0];
    end

    // Controller next state, together with the values the output flops load.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        step_d      = step_q;
        len_d       = len_q;
        pat_d       = pat_q;
        prio1_d     = prio1_q;
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        out_valid_d = 1'b0;
        out_val_d   = 3'd0;
        done_d      = 1'b0;
        done_id_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = win1_s;
                    prio1_d = ~win1_s;
                    pat_d   = win1_s ? pat1 : pat0;
                    len_d   = eff_len(win1_s ? len1 : len0);
                    seq_d   = ZERO;
                    step_d  = 4'd0;
                    gnt0_d  = ~win1_s;
                    gnt1_d  = win1_s;
                    if (len_d == 4'd0) begin
                        // An empty run completes in the same cycle as its grant.
                        state_d   = DONE;
                        done_d    = 1'b1;
                        done_id_d = win1_s;
                    end else begin
                        state_d     = RUN;
                        out_valid_d = 1'b1;
                        out_val_d   = ZERO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                seq_d  = seq_next(seq_q, step_bit_s);
                step_d = step_q + 4'd1;
                if (step_d == len_q) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else begin
                    state_d     = RUN;
                    out_valid_d = 1'b1;
                    out_val_d   = seq_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset dominates every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seq_q       <= ZERO;
            step_q      <= 4'd0;
            len_q       <= 4'd0;
            pat_q       <= '0;
            prio1_q     <= 1'b0;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_val_q   <= 3'd0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            step_q      <= step_d;
            len_q       <= len_d;
            pat_q       <= pat_d;
            prio1_q     <= prio1_d;
            owner_q     <= owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign done      = done_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_fsm_sched.sv
// tb_fsm_sched: directed and randomized runs of fsm_sched against a
// table-driven reference model of the arbitration and the sequence machine.
module tb_fsm_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] pat0, pat1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, busy, out_valid, done, done_id;
    logic [2:0] out_val;

    int tests = 0;
    int fails = 0;
    bit prio1 = 1'b0;   // model: 1 when requester 1 wins a tie

    // Reference tables, indexed by state name Z=0, T=1, D=2, Q=3, C=4.
    int enc  [5] = '{2, 6, 5, 4, 3};
    int nxt0 [5] = '{1, 2, 3, 0, 2};
    int nxt1 [5] = '{1, 4, 3, 1, 2};

    fsm_sched #(.PW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .pat0(pat0), .pat1(pat1),
        .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .out_valid(out_valid), .out_val(out_val),
        .done(done), .done_id(done_id)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Present a request in an IDLE cycle and check the whole run up to the next IDLE cycle.
    task automatic serve(input bit r0, input bit r1, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [3:0] l0, input logic [3:0] l1);
        int w, len, s;
        logic [7:0] p;
        int exp_q[$];
        check("idle_busy", busy, 8'd0);
        check("idle_valid", out_valid, 8'd0);
        req0 = r0; req1 = r1; pat0 = p0; pat1 = p1; len0 = l0; len1 = l1;
        if (r0 && r1) w = prio1 ? 1 : 0;
        else          w = r1 ? 1 : 0;
        p   = (w == 1) ? p1 : p0;
        len = (w == 1) ? int'(l1) : int'(l0);
        if (len > 8) len = 8;
        s = 0;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(enc[s]);
            s = p[k] ? nxt1[s] : nxt0[s];
        end
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            check("run_gnt0", gnt0, (i == 1 && w == 0) ? 8'd1 : 8'd0);
            check("run_gnt1", gnt1, (i == 1 && w == 1) ? 8'd1 : 8'd0);
            check("run_busy", busy, 8'd1);
            check("run_valid", out_valid, 8'd1);
            check("run_val", out_val, 8'(exp_q[i-1]));
            check("run_done", done, 8'd0);
            if (i == 1) begin
                if (w == 1) req1 = 1'b0;
                else        req0 = 1'b0;
            end
        end
        @(negedge clk);
        check("done_pulse", done, 8'd1);
        check("done_id", done_id, 8'(w));
        check("done_valid", out_valid, 8'd0);
        check("done_val", out_val, 8'd0);
        check("done_busy", busy, 8'd1);
        check("done_gnt0", gnt0, (len == 0 && w == 0) ? 8'd1 : 8'd0);
        check("done_gnt1", gnt1, (len == 0 && w == 1) ? 8'd1 : 8'd0);
        if (len == 0) begin
            if (w == 1) req1 = 1'b0;
            else        req0 = 1'b0;
        end
        @(negedge clk);
        check("post_busy", busy, 8'd0);
        check("post_done", done, 8'd0);
        check("post_gnt", {6'd0, gnt1, gnt0}, 8'd0);
        prio1 = (w == 0);
    endtask

    // Linear sequence of directed and random steps.
    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        pat0 = 8'h00; pat1 = 8'h00; len0 = 4'd0; len1 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_outs", {gnt0, gnt1, busy, out_valid, done, done_id, 2'b00}, 8'd0);
        check("rst_val", out_val, 8'd0);
        reset = 1'b0;
        prio1 = 1'b0;
        @(negedge clk);

        serve(1'b1, 1'b0, 8'h00, 8'h00, 4'd5, 4'd0);
        serve(1'b0, 1'b1, 8'h00, 8'hFF, 4'd0, 4'd6);
        // Simultaneous requests alternate, starting from req0 after reset.
        reset = 1'b1; @(negedge clk); reset = 1'b0; prio1 = 1'b0;
        serve(1'b1, 1'b1, 8'hA5, 8'h3C, 4'd2, 4'd2);
        serve(1'b0, 1'b1, 8'hA5, 8'h3C, 4'd2, 4'd2);
        serve(1'b1, 1'b1, 8'h5A, 8'hC3, 4'd2, 4'd2);
        serve(1'b1, 1'b0, 8'hFF, 8'h00, 4'd0, 4'd0);
        serve(1'b1, 1'b0, 8'h96, 8'h00, 4'd12, 4'd0);

        for (int n = 0; n < 30; n++) begin
            logic [1:0] rr;
            rr = 2'($urandom_range(1, 3));
            serve(rr[0], rr[1], 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Reset during step 3 of an 8-step run aborts it silently.
        req1 = 1'b0; req0 = 1'b1; pat0 = 8'($urandom); len0 = 4'd8;
        @(negedge clk);
        req0 = 1'b0;
        check("abort_start", out_valid, 8'd1);
        repeat (3) @(negedge clk);
        check("abort_step3", out_valid, 8'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", out_valid, 8'd0);
        check("abort_busy", busy, 8'd0);
        check("abort_done", done, 8'd0);
        check("abort_val", out_val, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_quiet", {done, busy, out_valid}, 8'd0);
        end
        prio1 = 1'b0;
        serve(1'b1, 1'b1, 8'h0F, 8'hF0, 4'd3, 4'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
